// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  // Ticks per bit period; the tick generator divides clk down to this rate.
  localparam int OVERSAMPLE = 16;
  // Tick index (counted from the start edge) at which the start bit is checked.
  localparam int MID_TICK   = 7;

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received words with their error flags.
// Handshake: push is accepted when not full, or when full and an accepted
// pop happens in the same cycle; pop is accepted only when not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             push_acc, pop_acc;

  assign pop_acc  = pop & ~empty_q;
  assign push_acc = push & (~full_q | pop_acc);

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_acc, pop_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  // Head is forced to zero while empty so outputs are defined after reset.
  assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, 16x tick generator, frame FSM, shift register
// and an error-tagging receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 overrun,
  output rx_state_t            dbg_state_o
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int WW = DATA_BITS + 2;
  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
  localparam logic [3:0]    OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    OS_MID    = 4'(MID_TICK);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]           sync_vld_q;
  logic [TW-1:0]        tick_cnt_q;
  logic                 tick, start_det;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [WW-1:0]        word_q, word_d;
  logic                 push_q, push_d;
  logic                 overrun_q;
  logic                 fifo_full, fifo_empty, pop_acc;
  logic [WW-1:0]        fifo_rdata;

  // Two-flop synchronizer plus previous-sample register for edge detection.
  // sync_vld_q marks when the synchronizer holds real line samples rather than
  // its reset value, so ARM cannot mistake the reset value for an idle line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Free-running 1/16-bit tick divider, realigned to each start edge.
  always_ff @(posedge clk) begin
    if (!reset)                              tick_cnt_q <= '0;
    else if (start_det || tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
    else                                     tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Frame FSM next-state, sampling and push generation.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    word_d    = word_q;
    push_d    = 1'b0;
    start_det = 1'b0;
    case (state_q)
      ARM: begin
        if (sync_vld_q[1] && rx_s_q) state_d = IDLE;
      end
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          start_det = 1'b1;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          par_d     = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            state_d  = rx_s_q ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d  = '0;
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            par_d    = (^shift_q) ^ rx_s_q;
            state_d  = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            word_d   = {~rx_s_q, par_q, shift_q};
            push_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  // FSM and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ARM;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      word_q    <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      word_q    <= word_d;
      push_q    <= push_d;
    end
  end

  assign pop_acc = rd_en & ~fifo_empty;

  // Sticky overrun: set when a push meets a full FIFO with no pop, cleared by a pop.
  always_ff @(posedge clk) begin
    if (!reset)                             overrun_q <= 1'b0;
    else if (pop_acc)                       overrun_q <= 1'b0;
    else if (push_q && fifo_full)           overrun_q <= 1'b1;
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .wdata (word_q),
    .pop   (rd_en),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign d_out       = fifo_rdata[DATA_BITS-1:0];
  assign parity_err  = fifo_rdata[DATA_BITS];
  assign frame_err   = fifo_rdata[DATA_BITS+1];
  assign rx_empty    = fifo_empty;
  assign rx_full     = fifo_full;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule
